run_sequencer: RTL



---
 rtl/run_seq_pkg.sv | 22 ++
 rtl/run_seq_if.sv | 24 ++
 rtl/run_cycle_counter.sv | 19 +
 rtl/run_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and default constants for the run sequencer.
package run_seq_pkg;

  localparam int DEF_CNT_W          = 32;
  localparam int DEF_START_LEN      = 1;
  localparam int DEF_HALT_MASK      = 2;
  localparam int DEF_TIMEOUT_CYCLES = 10000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_e;

  // States from which a run_req may launch a new run.
  function automatic logic can_launch(input run_state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/run_seq_if.sv
// Host/core handshake bundle for the run sequencer.
// master = sequencer side, slave = host/core side.
interface run_seq_if #(
  parameter int CNT_W = run_seq_pkg::DEF_CNT_W
);
  logic             run_req;
  logic             abort;
  logic             start;
  logic             halt;
  logic             busy;
  logic             done;
  logic             timed_out;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  run_req, abort, halt,
    output start, busy, done, timed_out, cycle_count
  );

  modport slave (
    output run_req, abort, halt,
    input  start, busy, done, timed_out, cycle_count
  );
endinterface

// File: rtl/run_cycle_counter.sv
// Saturating up-counter with synchronous clear (clear beats enable).
module run_cycle_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // count up while enabled, stick at all-ones
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && cnt != '1)  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/run_sequencer.sv
// Run controller: launches the core with a start pulse, masks stale halt,
// then measures RUN cycles until halt or declares a timeout.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int START_LEN      = DEF_START_LEN,
  parameter int HALT_MASK      = DEF_HALT_MASK,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic     CLK,
  input  logic     RST_N,
  run_seq_if.master bus
);

  localparam int               SW         = $clog2(START_LEN + 1);
  localparam logic [SW-1:0]    START_LAST = SW'(START_LEN - 1);
  localparam logic [CNT_W:0]   MASK_EXT   = (CNT_W + 1)'(HALT_MASK);
  localparam logic [CNT_W-1:0] TO_VAL     = CNT_W'(TIMEOUT_CYCLES);
  localparam logic             TO_EN      = (TIMEOUT_CYCLES != 0);

  if (START_LEN < 1) begin : g_bad_start_len
    $error("run_sequencer: START_LEN must be >= 1");
  end
  if (HALT_MASK < 0) begin : g_bad_halt_mask
    $error("run_sequencer: HALT_MASK must be >= 0");
  end
  if (TIMEOUT_CYCLES < 0 ||
      (CNT_W < 31 && TIMEOUT_CYCLES >= (1 << CNT_W))) begin : g_bad_timeout
    $error("run_sequencer: TIMEOUT_CYCLES does not fit in CNT_W bits");
  end

  run_state_e       state;
  logic             start_r, busy_r, done_r, to_r;
  logic [CNT_W-1:0] cnt;
  logic [SW-1:0]    scnt;
  logic             in_mask, timeout_hit, launch, cnt_en, scnt_en;

  // The mask window is measured by cycle_count itself: it starts at 0 on
  // entry to RUN and increments on every masked cycle.
  assign in_mask     = {1'b0, cnt} < MASK_EXT;
  assign timeout_hit = TO_EN && (cnt == TO_VAL);
  assign launch      = !bus.abort && bus.run_req && can_launch(state);

  // Count RUN cycles; halt after the mask or a timeout freezes the value.
  assign cnt_en  = !bus.abort && (state == ST_RUN) &&
                   (in_mask || (!bus.halt && !timeout_hit));
  assign scnt_en = !bus.abort && (state == ST_START);

  run_cycle_counter #(.W(CNT_W)) u_cycle_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (launch),
    .en    (cnt_en),
    .cnt   (cnt)
  );

  run_cycle_counter #(.W(SW)) u_start_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (launch),
    .en    (scnt_en),
    .cnt   (scnt)
  );

  // Main FSM; all handshake outputs are registered here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      start_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      to_r    <= 1'b0;
    end else if (bus.abort) begin
      state   <= ST_IDLE;
      start_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      to_r    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          if (bus.run_req) begin
            state   <= ST_START;
            start_r <= 1'b1;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            to_r    <= 1'b0;
          end
        end
        ST_START: begin
          if (scnt == START_LAST) begin
            state   <= ST_RUN;
            start_r <= 1'b0;
          end
        end
        ST_RUN: begin
          // halt beats the timeout when both land on the same cycle
          if (!in_mask && bus.halt) begin
            state  <= ST_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else if (!in_mask && timeout_hit) begin
            state  <= ST_TIMEOUT;
            busy_r <= 1'b0;
            to_r   <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          start_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start       = start_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.timed_out   = to_r;
  assign bus.cycle_count = cnt;

endmodule
